// File: rtl/tans_bit_packer.sv
// Packs variable-length tANS recoder chunks LSB-first into fixed-width words;
// on flush appends the recoder final state, zero-pads and tags the last word.
module tans_bit_packer #(
    parameter int WORD_W  = 8,
    parameter int DATA_W  = 3,
    parameter int NBITS_W = 2,
    parameter int STATE_W = 4
) (
    input  logic                         PHI,
    input  logic                         RST,
    input  logic                         in_valid,
    input  logic [NBITS_W-1:0]           in_nbits,
    input  logic [DATA_W-1:0]            in_bits,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic [STATE_W-1:0]           final_state,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_word,
    output logic [$clog2(WORD_W+1)-1:0]  out_nbits,
    output logic                         out_last
);
    // state      | meaning
    // RUN        | accepting chunks, emitting full words
    // FLUSH_ST   | draining full words, then appending the final state
    // FLUSH_DATA | draining remaining bits, last partial word tagged out_last

    localparam int ACC_W  = WORD_W + STATE_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int ONB_W  = $clog2(WORD_W + 1);
    localparam logic [FILL_W-1:0] WORD_F  = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] STATE_F = FILL_W'(STATE_W);

    typedef enum logic [1:0] {RUN, FLUSH_ST, FLUSH_DATA} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt, acc_sh;
    logic [FILL_W-1:0]   fill, fill_nxt, fill_sh;
    logic [STATE_W-1:0]  fs_q;
    logic [DATA_W-1:0]   chunk;
    logic                ofree, accept, xfer, fs_append, last_load, flush_take;

    assign ofree  = !out_valid || out_ready;
    assign accept = in_valid && in_ready;

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (flush)     state_nxt = FLUSH_ST;
            FLUSH_ST:   if (fs_append) state_nxt = FLUSH_DATA;
            FLUSH_DATA: if (last_load) state_nxt = RUN;
            default:                   state_nxt = RUN;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        xfer       = 1'b0;
        fs_append  = 1'b0;
        last_load  = 1'b0;
        flush_take = 1'b0;
        case (state)
            RUN: begin
                in_ready   = (fill < WORD_F) || ofree;
                xfer       = (fill >= WORD_F) && ofree;
                flush_take = flush;
            end
            FLUSH_ST: begin
                xfer      = (fill >= WORD_F) && ofree;
                fs_append = fill < WORD_F;
            end
            FLUSH_DATA: begin
                // fill is never 0 here: the final state always adds STATE_W bits
                xfer      = (fill > WORD_F) && ofree;
                last_load = (fill <= WORD_F) && (fill != '0) && ofree;
            end
            default: ;
        endcase
    end

    always_comb begin
        chunk = '0;
        for (int i = 0; i < DATA_W; i++)
            chunk[i] = (i < int'(in_nbits)) ? in_bits[i] : 1'b0;
        acc_sh   = xfer ? (acc >> WORD_W) : acc;
        fill_sh  = xfer ? (fill - WORD_F) : fill;
        acc_nxt  = acc_sh;
        fill_nxt = fill_sh;
        if (accept) begin
            acc_nxt  = acc_sh | (ACC_W'(chunk) << fill_sh);
            fill_nxt = fill_sh + FILL_W'(in_nbits);
        end
        if (fs_append) begin
            acc_nxt  = acc | (ACC_W'(fs_q) << fill);
            fill_nxt = fill + STATE_F;
        end
        if (last_load) begin
            acc_nxt  = '0;
            fill_nxt = '0;
        end
    end

    always_ff @(posedge PHI or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            fill      <= '0;
            fs_q      <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_nbits <= '0;
            out_last  <= 1'b0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
            if (flush_take) fs_q <= final_state;
            if (xfer) begin
                out_word  <= acc[WORD_W-1:0];
                out_nbits <= ONB_W'(WORD_W);
                out_last  <= 1'b0;
                out_valid <= 1'b1;
            end else if (last_load) begin
                out_word  <= acc[WORD_W-1:0];
                out_nbits <= ONB_W'(fill);
                out_last  <= 1'b1;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tans_bit_packer.sv
// Self-checking bench for tans_bit_packer: a bit-queue reference model builds
// the expected word stream from accepted chunks and flushes.
module tb_tans_bit_packer;
    logic       PHI = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_nbits = '0;
    logic [2:0] in_bits = '0;
    logic       in_ready;
    logic       flush = 1'b0;
    logic [3:0] final_state = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_word;
    logic [3:0] out_nbits;
    logic       out_last;

    typedef logic [12:0] wrec_t;   // {word, nbits, last}

    int    checks = 0;
    int    errors = 0;
    int    ready_low = 0;
    wrec_t exp_q[$];
    wrec_t obs_q[$];
    bit    bitq[$];
    bit    model_run = 1'b1;

    tans_bit_packer dut (
        .PHI(PHI), .RST(RST), .in_valid(in_valid), .in_nbits(in_nbits),
        .in_bits(in_bits), .in_ready(in_ready), .flush(flush),
        .final_state(final_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_nbits(out_nbits), .out_last(out_last)
    );

    always #5 PHI = ~PHI;

    function automatic wrec_t pop_word(input int n, input bit last);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i] = bitq.pop_front();
        return {w, 4'(n), last};
    endfunction

    // Reference model: the stream is a plain bit queue cut into 8-bit words.
    always @(negedge PHI) begin
        if (!RST) begin
            if (!in_ready) ready_low++;
            if (in_valid && in_ready)
                for (int i = 0; i < int'(in_nbits); i++) bitq.push_back(in_bits[i]);
            while (bitq.size() >= 8) exp_q.push_back(pop_word(8, 1'b0));
            if (flush && model_run) begin
                for (int i = 0; i < 4; i++) bitq.push_back(final_state[i]);
                while (bitq.size() > 8) exp_q.push_back(pop_word(8, 1'b0));
                exp_q.push_back(pop_word(bitq.size(), 1'b1));
                model_run = 1'b0;
            end
            if (out_valid && out_ready) begin
                obs_q.push_back({out_word, out_nbits, out_last});
                if (out_last) model_run = 1'b1;
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        bitq.delete();
        model_run = 1'b1;
    endtask

    task automatic send(input logic [1:0] n, input logic [2:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_nbits = n;
        in_bits  = b;
        @(negedge PHI);
        while (!in_ready && t < 100) begin
            @(negedge PHI);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge PHI);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush(input logic [3:0] s);
        flush = 1'b1;
        final_state = s;
        @(posedge PHI);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((obs_q.size() < exp_q.size() || !model_run) && t < 500) begin
            @(negedge PHI);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout observed=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        repeat (4) @(negedge PHI);
        @(posedge PHI);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge PHI);
        #1;
        checks++;
        if ({out_valid, out_word, out_nbits, out_last} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", {out_valid, out_word, out_nbits, out_last});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
        RST = 1'b0;
        clear_model();
    endtask

    task automatic test_pack();
        out_ready = 1'b1;
        ready_low = 0;
        send(2'd3, 3'b101);
        send(2'd3, 3'b110);
        send(2'd2, 3'b001);
        wait_drain();
        checks++;
        if (ready_low !== 0) begin
            errors++;
            $display("FAIL pack_in_ready_low cycles=%0d required=0", ready_low);
        end
        checks++;
        if (obs_q.size() !== 1) begin
            errors++;
            $display("FAIL pack_count got=%0d required=1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {8'h75, 4'd8, 1'b0}) begin
                errors++;
                $display("FAIL pack_word got=%h required=%h", obs_q[0], {8'h75, 4'd8, 1'b0});
            end
        end
        clear_model();
    endtask

    task automatic test_flush_partial();
        send(2'd3, 3'b011);
        pulse_flush(4'b1010);
        wait_drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {8'h53, 4'd7, 1'b1}) begin
            errors++;
            $display("FAIL flush_partial got=%h count=%0d required=%h", obs_q.size() > 0 ? obs_q[0] : 13'h0, obs_q.size(), {8'h53, 4'd7, 1'b1});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_partial_run in_ready=%b required=1", in_ready);
        end
        clear_model();
    endtask

    task automatic test_flush_spill();
        send(2'd3, 3'b111);
        send(2'd3, 3'b000);
        pulse_flush(4'b1111);
        wait_drain();
        checks++;
        if (obs_q.size() !== 2) begin
            errors++;
            $display("FAIL spill_count got=%0d required=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {8'hC7, 4'd8, 1'b0}) begin
                errors++;
                $display("FAIL spill_word0 got=%h required=%h", obs_q[0], {8'hC7, 4'd8, 1'b0});
            end
            checks++;
            if (obs_q[1] !== {8'h03, 4'd2, 1'b1}) begin
                errors++;
                $display("FAIL spill_word1 got=%h required=%h", obs_q[1], {8'h03, 4'd2, 1'b1});
            end
        end
        clear_model();
    endtask

    task automatic test_masking();
        send(2'd1, 3'b110);
        send(2'd2, 3'bx01);
        pulse_flush(4'b0000);
        wait_drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {8'h02, 4'd7, 1'b1}) begin
            errors++;
            $display("FAIL masking got=%h count=%0d required=%h", obs_q.size() > 0 ? obs_q[0] : 13'h0, obs_q.size(), {8'h02, 4'd7, 1'b1});
        end
        clear_model();
        pulse_flush(4'b1001);
        wait_drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {8'h09, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL empty_flush got=%h count=%0d required=%h", obs_q.size() > 0 ? obs_q[0] : 13'h0, obs_q.size(), {8'h09, 4'd4, 1'b1});
        end
        clear_model();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            in_nbits = 2'd3;
            in_bits  = 3'($urandom);
            @(posedge PHI);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall in_ready=%b out_valid=%b required=0,1", in_ready, out_valid);
        end
        checks++;
        if (exp_q.size() < 1 || out_word !== exp_q[0][12:5]) begin
            errors++;
            $display("FAIL bp_held_word got=%h required=%h", out_word, exp_q.size() > 0 ? exp_q[0][12:5] : 8'h0);
        end
        repeat (5) @(posedge PHI);
        #1;
        checks++;
        if (exp_q.size() < 1 || {out_word, out_nbits, out_last} !== exp_q[0] || obs_q.size() !== 0) begin
            errors++;
            $display("FAIL bp_stable got=%h consumed=%0d required=%h", {out_word, out_nbits, out_last}, obs_q.size(), exp_q.size() > 0 ? exp_q[0] : 13'h0);
        end
        pulse_flush(4'($urandom));
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_word%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid    = $urandom_range(0, 3) != 0;
            in_nbits    = 2'($urandom_range(0, 3));
            in_bits     = 3'($urandom);
            out_ready   = $urandom_range(0, 3) != 0;
            final_state = 4'($urandom);
            flush       = model_run && ($urandom_range(0, 19) == 0);
            @(posedge PHI);
            #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        pulse_flush(4'($urandom));
        wait_drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d required=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
            end
        end
        clear_model();
    endtask

    task automatic test_reset_mid_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_nbits = 2'd3;
            in_bits  = 3'($urandom);
            @(posedge PHI);
            #1;
        end
        in_valid = 1'b0;
        pulse_flush(4'b0110);
        @(posedge PHI);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_word, out_nbits, out_last} !== 14'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midflush_reset got=%h in_ready=%b required=0,1", {out_valid, out_word, out_nbits, out_last}, in_ready);
        end
        clear_model();
        @(posedge PHI);
        #1;
        RST = 1'b0;
        out_ready = 1'b1;
        send(2'd3, 3'b101);
        send(2'd3, 3'b110);
        send(2'd2, 3'b001);
        wait_drain();
        checks++;
        if (obs_q.size() !== 1 || obs_q[0] !== {8'h75, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL midflush_after got=%h count=%0d required=%h", obs_q.size() > 0 ? obs_q[0] : 13'h0, obs_q.size(), {8'h75, 4'd8, 1'b0});
        end
        clear_model();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        @(posedge PHI);
        #1;
        test_pack();
        test_flush_partial();
        test_flush_spill();
        test_masking();
        test_backpressure();
        test_random();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
